dcache_miss_ctrl: RTL and testbench

- Sequencing controller between the CPU load/store port, the data cache and main memory.
- Drives the cache's request/load interface and consumes its hit/miss/evict/blkOut responses.
- On a miss, writes back the dirty victim block, fetches the new 512b line, loads it with ld, then replays the access.
- Keeps a shadow tag copy so the writeback address can be formed; the cache does not output the victim tag.

---
 rtl/dcache_pkg.sv | 23 ++
 rtl/dcache_shadow_tags.sv | 25 ++
 rtl/dcache_miss_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared address-field constants and controller state encoding
// for the data cache and its miss sequencer.
package dcache_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int OFFSET_BITS = 4;
    localparam int INDEX_BITS  = 8;
    localparam int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int WORDS       = 1 << OFFSET_BITS;
    localparam int WORD_SIZE   = 32;
    localparam int BLOCK_SIZE  = WORDS * WORD_SIZE;
    localparam int CNT_WIDTH   = 16;

    typedef enum logic [2:0] {
        IDLE,
        CMP,
        WB,
        ALLOC,
        FILL,
        DONE
    } state_t;

endpackage

// File: rtl/dcache_shadow_tags.sv
// Copy of the per-line tags loaded through the miss controller,
// used to rebuild the victim address on writeback.
module dcache_shadow_tags #(
    parameter int INDEX_BITS = 8,
    parameter int TAG_BITS   = 20
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] windex,
    input  logic [TAG_BITS-1:0]   wtag,
    input  logic [INDEX_BITS-1:0] rindex,
    output logic [TAG_BITS-1:0]   rtag
);

    logic [TAG_BITS-1:0] tags [1<<INDEX_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            tags[windex] <= wtag;
        end
    end

    assign rtag = tags[rindex];

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Sequences CPU accesses through the data cache, handling
// dirty-victim writeback, line fill and replay on a miss.
module dcache_miss_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int OFFSET_BITS = 4,
    parameter int INDEX_BITS  = 8,
    parameter int WORD_SIZE   = 32,
    parameter int BLOCK_SIZE  = 512,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0]  cpu_dataIn,
    output logic                  cpu_ready,
    output logic                  cpu_done,
    output logic [WORD_SIZE-1:0]  cpu_dataOut,
    output logic                  cache_en,
    output logic                  cache_rd,
    output logic                  cache_wr,
    output logic                  cache_ld,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [WORD_SIZE-1:0]  cache_dataIn,
    output logic [BLOCK_SIZE-1:0] cache_blkIn,
    input  logic                  cache_hit,
    input  logic                  cache_miss,
    input  logic                  cache_evict,
    input  logic [WORD_SIZE-1:0]  cache_dataOut,
    input  logic [BLOCK_SIZE-1:0] cache_blkOut,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BLOCK_SIZE-1:0] mem_wdata,
    input  logic [BLOCK_SIZE-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [CNT_WIDTH-1:0]  miss_cnt,
    output logic [CNT_WIDTH-1:0]  wb_cnt
);

    import dcache_pkg::*;

    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;

    state_t                state_q, state_d;
    logic                  op_wr_q;
    logic                  replay_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_SIZE-1:0]  data_q;
    logic [WORD_SIZE-1:0]  rdata_q;
    logic [BLOCK_SIZE-1:0] victim_q;
    logic [BLOCK_SIZE-1:0] line_q;
    logic [CNT_WIDTH-1:0]  miss_q;
    logic [CNT_WIDTH-1:0]  wb_q;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_W-1:0]      tag;
    logic [TAG_W-1:0]      vtag;
    logic                  accept;
    logic                  fill;

    assign index  = addr_q[OFFSET_BITS +: INDEX_BITS];
    assign tag    = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign accept = (state_q == IDLE) && (cpu_rd ^ cpu_wr);
    assign fill   = (state_q == FILL);

    dcache_shadow_tags #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_W)
    ) u_tags (
        .clk   (clk),
        .we    (fill),
        .windex(index),
        .wtag  (tag),
        .rindex(index),
        .rtag  (vtag)
    );

    assign cache_addr   = addr_q;
    assign cache_dataIn = data_q;
    assign cache_blkIn  = line_q;
    assign mem_wdata    = victim_q;
    assign miss_cnt     = miss_q;
    assign wb_cnt       = wb_q;

    always_comb begin
        state_d     = state_q;
        cpu_ready   = 1'b0;
        cpu_done    = 1'b0;
        cpu_dataOut = '0;
        cache_en    = 1'b0;
        cache_rd    = 1'b0;
        cache_wr    = 1'b0;
        cache_ld    = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        unique case (state_q)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_rd ^ cpu_wr) state_d = CMP;
            end
            CMP: begin
                cache_en = 1'b1;
                cache_rd = !op_wr_q;
                cache_wr = op_wr_q;
                if (cache_hit) state_d = DONE;
                else if (cache_miss) state_d = cache_evict ? WB : ALLOC;
            end
            WB: begin
                mem_wr   = 1'b1;
                mem_addr = {vtag, index, {OFFSET_BITS{1'b0}}};
                if (mem_ack) state_d = ALLOC;
            end
            ALLOC: begin
                mem_rd   = 1'b1;
                mem_addr = {tag, index, {OFFSET_BITS{1'b0}}};
                if (mem_ack) state_d = FILL;
            end
            FILL: begin
                cache_en = 1'b1;
                cache_ld = 1'b1;
                state_d  = CMP;
            end
            DONE: begin
                cpu_done    = 1'b1;
                cpu_dataOut = rdata_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The replay after a fill must not be counted as a second miss
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_wr_q  <= 1'b0;
            replay_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            victim_q <= '0;
            line_q   <= '0;
            miss_q   <= '0;
            wb_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= cpu_addr;
                data_q   <= cpu_dataIn;
                op_wr_q  <= cpu_wr;
                replay_q <= 1'b0;
            end
            if (state_q == CMP) begin
                if (cache_hit) begin
                    rdata_q <= op_wr_q ? '0 : cache_dataOut;
                end else if (cache_miss) begin
                    if (cache_evict) victim_q <= cache_blkOut;
                    if (!replay_q && miss_q != '1) miss_q <= miss_q + 1'b1;
                end
            end
            if (state_q == WB && mem_ack && wb_q != '1) wb_q <= wb_q + 1'b1;
            if (state_q == ALLOC && mem_ack) line_q <= mem_rdata;
            if (fill) replay_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl with a behavioural
// data cache and a fixed-latency line memory.
module tb_dcache_miss_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cpu_rd = 1'b0;
    logic         cpu_wr = 1'b0;
    logic [31:0]  cpu_addr = '0;
    logic [31:0]  cpu_dataIn = '0;
    logic         cpu_ready, cpu_done;
    logic [31:0]  cpu_dataOut;
    logic         cache_en, cache_rd, cache_wr, cache_ld;
    logic [31:0]  cache_addr, cache_dataIn;
    logic [511:0] cache_blkIn;
    logic         cache_hit, cache_miss, cache_evict;
    logic [31:0]  cache_dataOut;
    logic [511:0] cache_blkOut;
    logic         mem_rd, mem_wr;
    logic [31:0]  mem_addr;
    logic [511:0] mem_wdata;
    logic [511:0] mem_rdata = '0;
    logic         mem_ack;
    logic [15:0]  miss_cnt, wb_cnt;

    always #5 clk = ~clk;

    dcache_miss_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_rd       (cpu_rd),
        .cpu_wr       (cpu_wr),
        .cpu_addr     (cpu_addr),
        .cpu_dataIn   (cpu_dataIn),
        .cpu_ready    (cpu_ready),
        .cpu_done     (cpu_done),
        .cpu_dataOut  (cpu_dataOut),
        .cache_en     (cache_en),
        .cache_rd     (cache_rd),
        .cache_wr     (cache_wr),
        .cache_ld     (cache_ld),
        .cache_addr   (cache_addr),
        .cache_dataIn (cache_dataIn),
        .cache_blkIn  (cache_blkIn),
        .cache_hit    (cache_hit),
        .cache_miss   (cache_miss),
        .cache_evict  (cache_evict),
        .cache_dataOut(cache_dataOut),
        .cache_blkOut (cache_blkOut),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .miss_cnt     (miss_cnt),
        .wb_cnt       (wb_cnt)
    );

    // behavioural direct-mapped cache
    logic         m_valid [256];
    logic         m_dirty [256];
    logic [19:0]  m_tag   [256];
    logic [511:0] m_line  [256];
    logic [7:0]   m_idx;
    logic [3:0]   m_off;
    int           n_ld = 0;

    assign m_idx         = cache_addr[11:4];
    assign m_off         = cache_addr[3:0];
    assign cache_hit     = m_valid[m_idx] && (m_tag[m_idx] == cache_addr[31:12]);
    assign cache_miss    = !cache_hit;
    assign cache_evict   = cache_miss && m_valid[m_idx] && m_dirty[m_idx];
    assign cache_dataOut = m_line[m_idx][m_off*32 +: 32];
    assign cache_blkOut  = m_line[m_idx];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                m_valid[i] <= 1'b0;
                m_dirty[i] <= 1'b0;
            end
        end else if (cache_en && cache_ld) begin
            m_line[m_idx]  <= cache_blkIn;
            m_tag[m_idx]   <= cache_addr[31:12];
            m_valid[m_idx] <= 1'b1;
            m_dirty[m_idx] <= 1'b0;
            n_ld           <= n_ld + 1;
        end else if (cache_en && cache_wr && cache_hit) begin
            m_line[m_idx][m_off*32 +: 32] <= cache_dataIn;
            m_dirty[m_idx] <= 1'b1;
        end
    end

    // line memory: acks on the fourth cycle of a request
    logic         ack_q = 1'b0;
    logic         ack_inj = 1'b0;
    logic         mem_hold = 1'b0;
    int           mwait = 0;
    int           n_rd = 0;
    int           n_wr = 0;
    int           n_both = 0;
    logic [31:0]  rd_addr = '0;
    logic [31:0]  wr_addr = '0;
    logic [511:0] wr_data = '0;

    assign mem_ack = ack_q | ack_inj;

    always @(posedge clk) begin
        ack_q <= 1'b0;
        if (mem_rd && mem_wr) n_both <= n_both + 1;
        if ((mem_rd || mem_wr) && !mem_ack && !mem_hold) begin
            if (mwait == 2) begin
                ack_q <= 1'b1;
                mwait <= 0;
                if (mem_wr) begin
                    n_wr    <= n_wr + 1;
                    wr_addr <= mem_addr;
                    wr_data <= mem_wdata;
                end else begin
                    n_rd    <= n_rd + 1;
                    rd_addr <= mem_addr;
                end
            end else begin
                mwait <= mwait + 1;
            end
        end else begin
            mwait <= 0;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [511:0] got,
                         input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // present one request and wait for its completion pulse
    task automatic do_req(input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] q);
        cpu_rd     = rd;
        cpu_wr     = wr;
        cpu_addr   = a;
        cpu_dataIn = d;
        @(posedge clk); #1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        lat = 1;
        while (!cpu_done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        q = cpu_dataOut;
        check("req_done", cpu_done, 1'b1);
        @(posedge clk); #1;
    endtask

    logic [511:0] fill;
    int           lat;
    logic [31:0]  q;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", cpu_ready, 1'b1);
        check("rst_outs", {cpu_done, cache_en, cache_ld, mem_rd, mem_wr}, 5'b0);
        check("rst_cnt", {miss_cnt, wb_cnt}, 32'h0);
        check("rst_addr", cache_addr, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) fill[i*32 +: 32] = 32'h1000_0000 + i;
        fill[31:0] = 32'hDEAD_BEEF;
        mem_rdata = fill;
        do_req(1'b1, 1'b0, 32'h0000_1230, 32'h0, lat, q);
        check("cold_data", q, 32'hDEAD_BEEF);
        check("cold_lat", lat, 8);
        check("cold_rd", {n_rd, rd_addr}, {32'd1, 32'h0000_1230});
        check("cold_ld", n_ld, 1);
        check("cold_nowb", n_wr, 0);
        check("cold_cnt", {miss_cnt, wb_cnt}, {16'd1, 16'd0});

        do_req(1'b0, 1'b1, 32'h0000_1235, 32'hCAFE_0001, lat, q);
        check("wr_hit_lat", lat, 2);
        check("wr_hit_dout", q, 32'h0);
        do_req(1'b1, 1'b0, 32'h0000_1235, 32'h0, lat, q);
        check("rd_hit_lat", lat, 2);
        check("rd_hit_data", q, 32'hCAFE_0001);
        do_req(1'b1, 1'b0, 32'h0000_1237, 32'h0, lat, q);
        check("rd_hit_w7", q, 32'h1000_0007);
        check("hit_nomem", {n_rd, n_wr}, {32'd1, 32'd0});

        for (int i = 0; i < 16; i++) fill[i*32 +: 32] = 32'h2000_0000 + i;
        fill[31:0] = 32'h1111_0000;
        mem_rdata = fill;
        do_req(1'b1, 1'b0, 32'h0001_1230, 32'h0, lat, q);
        check("dirty_lat", lat, 12);
        check("wb_addr", {n_wr, wr_addr}, {32'd1, 32'h0000_1230});
        check("wb_w5", wr_data[191:160], 32'hCAFE_0001);
        check("wb_w0", wr_data[31:0], 32'hDEAD_BEEF);
        check("dirty_rd", {n_rd, rd_addr}, {32'd2, 32'h0001_1230});
        check("dirty_data", q, 32'h1111_0000);
        check("dirty_cnt", {miss_cnt, wb_cnt}, {16'd2, 16'd1});
        check("dirty_ld", n_ld, 2);

        cpu_rd   = 1'b1;
        cpu_wr   = 1'b1;
        cpu_addr = 32'h0000_9990;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("both_idle", {cpu_ready, cache_en}, 2'b10);
        end
        cpu_wr = 1'b0;
        cpu_addr = 32'h0001_1234;
        @(posedge clk); #1;
        cpu_rd     = 1'b0;
        cpu_wr     = 1'b1;
        cpu_addr   = 32'h0000_2000;
        cpu_dataIn = 32'h5555_5555;
        @(posedge clk); #1;
        check("busy_done", {cpu_done, cpu_dataOut}, {1'b1, 32'h2000_0004});
        @(posedge clk); #1;
        cpu_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("drop_idle", {cpu_ready, cache_en}, 2'b10);
        check("drop_addr", cache_addr, 32'h0001_1234);
        check("drop_cnt", miss_cnt, 16'd2);

        do_req(1'b0, 1'b1, 32'h0001_1238, 32'hABCD_0002, lat, q);
        mem_hold = 1'b1;
        cpu_rd   = 1'b1;
        cpu_addr = 32'h0002_1230;
        @(posedge clk); #1;
        cpu_rd = 1'b0;
        for (int i = 0; i < 10 && !mem_wr; i++) begin
            @(posedge clk); #1;
        end
        check("wb_entered", {mem_wr, mem_addr}, {1'b1, 32'h0001_1230});
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("wbrst_mem", {mem_rd, mem_wr}, 2'b00);
        check("wbrst_ready", {cpu_ready, cache_en}, 2'b10);
        check("wbrst_cnt", {miss_cnt, wb_cnt}, 32'h0);
        rst      = 1'b0;
        mem_hold = 1'b0;
        ack_inj  = 1'b1;
        @(posedge clk); #1;
        ack_inj = 1'b0;
        @(posedge clk); #1;
        check("late_ack", {cpu_ready, mem_rd, mem_wr, cache_en}, 4'b1000);

        force dut.miss_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.miss_q;
        @(posedge clk); #1;
        check("sat_preset", miss_cnt, 16'hFFFF);
        do_req(1'b1, 1'b0, 32'h0000_5670, 32'h0, lat, q);
        check("sat_lat", lat, 8);
        check("sat_data", q, 32'h1111_0000);
        check("sat_cnt", {miss_cnt, wb_cnt}, {16'hFFFF, 16'd0});
        check("never_both", n_both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
